// File: rtl/pov_string_packer.sv
// Packs printable UART bytes into a space-padded, double-buffered display string for the POV LED stage.
// Optional build macro POV_STRING_PACKER_UPCASE_EN folds lowercase letters to uppercase before storage.
module pov_string_packer #(
    parameter int                NCHARS = 11,
    parameter int                CHAR_W = 7,
    parameter logic [7:0]        TERM   = 8'h0D,
    parameter logic [CHAR_W-1:0] PAD    = 7'h20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_err,
    output logic [0:NCHARS*CHAR_W-1] String,
    output logic                     ready,
    output logic [0:CHAR_W-1]        CharSalida,
    output logic                     drop
);

    localparam int                 CNT_W    = $clog2(NCHARS + 1);
    localparam int                 STR_W    = NCHARS * CHAR_W;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(NCHARS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NCHARS - 1);
    localparam logic [0:STR_W-1]   PAD_STR  = {NCHARS{PAD}};

    typedef enum logic [1:0] {
        S_COLLECT,
        S_PAD,
        S_PUBLISH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [0:STR_W-1]   r_shadow;
    logic [0:STR_W-1]   r_string;
    logic [CHAR_W-1:0]  r_char;
    logic               r_ready;
    logic               r_drop;

    logic               w_accept;
    logic               w_is_term;
    logic               w_is_print;
    logic               w_wr_en;
    logic [CHAR_W-1:0]  w_wr_char;
    logic               w_cnt_inc;
    logic               w_upd_char;
    logic               w_publish;
    logic               w_drop;

    function automatic logic [CHAR_W-1:0] fold_char(input logic [6:0] c);
        logic [6:0] w_c;
        w_c = c;
`ifdef POV_STRING_PACKER_UPCASE_EN
        if (c >= 7'h61 && c <= 7'h7A) begin
            w_c = c - 7'h20;
        end
`endif
        return CHAR_W'(w_c);
    endfunction

    // Error bytes never count as traffic; bit-7 and control bytes are filtered only in COLLECT.
    assign w_accept   = rx_valid && !rx_err;
    assign w_is_term  = w_accept && !rx_data[7] && (rx_data == TERM);
    assign w_is_print = w_accept && !rx_data[7] && (rx_data != TERM) && (rx_data >= 8'h20);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_char   = PAD;
        w_cnt_inc   = 1'b0;
        w_upd_char  = 1'b0;
        w_publish   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (w_is_print) begin
                    w_wr_en    = 1'b1;
                    w_wr_char  = fold_char(rx_data[6:0]);
                    w_cnt_inc  = 1'b1;
                    w_upd_char = 1'b1;
                    // A full string spends one PAD cycle with nothing left to fill, then publishes.
                    if (r_count == CNT_LAST) begin
                        w_state_nxt = S_PAD;
                    end
                end else if (w_is_term && (r_count != '0)) begin
                    w_state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                w_drop = w_accept;
                if (r_count == CNT_FULL) begin
                    w_state_nxt = S_PUBLISH;
                end else begin
                    w_wr_en   = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            S_PUBLISH: begin
                w_drop      = w_accept;
                w_publish   = 1'b1;
                w_state_nxt = S_COLLECT;
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // NOTE: the shadow buffer is a handful of flops, not a RAM, so it is reset to spaces with everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_shadow <= PAD_STR;
            r_string <= PAD_STR;
            r_char   <= '0;
            r_ready  <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_ready <= w_publish;
            r_drop  <= w_drop;
            if (w_publish) begin
                r_string <= r_shadow;
                r_shadow <= PAD_STR;
                r_count  <= '0;
            end else begin
                if (w_wr_en) begin
                    for (int i = 0; i < NCHARS; i++) begin
                        if (r_count == CNT_W'(i)) begin
                            r_shadow[i*CHAR_W +: CHAR_W] <= w_wr_char;
                        end
                    end
                end
                if (w_cnt_inc) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            if (w_upd_char) begin
                r_char <= w_wr_char;
            end
        end
    end

    assign String     = r_string;
    assign ready      = r_ready;
    assign CharSalida = r_char;
    assign drop       = r_drop;

endmodule

// File: tb/tb_pov_string_packer.sv
// Randomized and directed bench for pov_string_packer, checked against a message-level reference model.
// Define POV_STRING_PACKER_UPCASE_EN for both bench and RTL to exercise the case-folding build.
module tb_pov_string_packer;

    localparam int NCHARS = 11;
    localparam int CHAR_W = 7;
    localparam int STR_W  = NCHARS * CHAR_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_err;
    logic [0:STR_W-1]    String;
    logic                ready;
    logic [0:CHAR_W-1]   CharSalida;
    logic                drop;

    pov_string_packer #(
        .NCHARS (NCHARS),
        .CHAR_W (CHAR_W),
        .TERM   (8'h0D),
        .PAD    (7'h20)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .String     (String),
        .ready      (ready),
        .CharSalida (CharSalida),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of collected characters plus the edge at which the padded copy appears.
    logic [6:0] msg[$];
    logic [6:0] exp_str[NCHARS];
    logic [6:0] pend_str[NCHARS];
    logic [6:0] exp_char;
    bit         pend;
    int         pub_at;
    int         busy_until;
    int         ecount = 0;
    bit         exp_ready;
    bit         exp_drop;

    int         n_ready = 0;
    int         n_drop  = 0;
    int         last_ready_edge = -100;

    function automatic logic [6:0] ref_fold(input logic [7:0] d);
        logic [6:0] c;
        c = d[6:0];
`ifdef POV_STRING_PACKER_UPCASE_EN
        if (c >= 7'd97 && c <= 7'd122) c = c - 7'd32;
`endif
        return c;
    endfunction

    function automatic logic [0:STR_W-1] flat_exp();
        logic [0:STR_W-1] v;
        for (int i = 0; i < NCHARS; i++) v[i*CHAR_W +: CHAR_W] = exp_str[i];
        return v;
    endfunction

    function automatic logic [0:STR_W-1] all_spaces();
        logic [0:STR_W-1] v;
        for (int i = 0; i < NCHARS; i++) v[i*CHAR_W +: CHAR_W] = 7'h20;
        return v;
    endfunction

    task automatic model_reset();
        msg.delete();
        for (int i = 0; i < NCHARS; i++) exp_str[i] = 7'h20;
        exp_char   = 7'h00;
        pend       = 1'b0;
        busy_until = -1;
        exp_ready  = 1'b0;
        exp_drop   = 1'b0;
    endtask

    task automatic schedule(input int at);
        for (int i = 0; i < NCHARS; i++) pend_str[i] = (i < msg.size()) ? msg[i] : 7'h20;
        pend       = 1'b1;
        pub_at     = at;
        busy_until = at;
        msg.delete();
    endtask

    task automatic model_edge(input logic v, input logic er, input logic [7:0] d);
        logic [6:0] c;
        ecount++;
        exp_ready = 1'b0;
        exp_drop  = 1'b0;
        if (pend && ecount == pub_at) begin
            for (int i = 0; i < NCHARS; i++) exp_str[i] = pend_str[i];
            exp_ready = 1'b1;
            pend      = 1'b0;
        end
        if (v && !er) begin
            if (ecount <= busy_until) begin
                exp_drop = 1'b1;
            end else if (d[7]) begin
                // high-bit bytes are ignored
            end else if (d == 8'h0D) begin
                if (msg.size() > 0) schedule(ecount + (NCHARS - msg.size()) + 2);
            end else if (d >= 8'h20) begin
                c = ref_fold(d);
                msg.push_back(c);
                exp_char = c;
                if (msg.size() == NCHARS) schedule(ecount + 2);
            end
        end
    endtask

    task automatic step(input logic v, input logic er, input logic [7:0] d);
        rx_valid = v;
        rx_err   = er;
        rx_data  = d;
        @(posedge clk);
        model_edge(v, er, d);
        @(negedge clk);
        if (ready) begin
            n_ready++;
            last_ready_edge = ecount;
        end
        if (drop) n_drop++;
        check("ready", ready, exp_ready);
        check("drop", drop, exp_drop);
        check("string", String, flat_exp());
        check("char", CharSalida, exp_char);
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, 1'b0, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic pulse_reset();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
        #2 reset = 1'b1;
        #1;
        check("rst_string", String, all_spaces());
        check("rst_ready", ready, 1'b0);
        check("rst_drop", drop, 1'b0);
        check("rst_char", CharSalida, 7'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int cr_edge;
        int k_edge;
        int n_ready_snap;
        int n_drop_snap;
        logic [6:0] exp_x;
        logic [7:0] b;

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        @(negedge clk);
        pulse_reset();
        idle(2);

        // Short message padded with spaces
        send_str("HOLA");
        send(8'h0D);
        cr_edge = ecount;
        idle(12);
        check("hola_latency", 32'(last_ready_edge - cr_edge), 32'd9);
        check("hola_char", CharSalida, 7'h41);
        check("hola_slot0", String[0:6], 7'h48);
        check("hola_slot4", String[28:34], 7'h20);

        // Full message, then CR-LF must not publish again
        send_str("ABCDEFGHIJK");
        k_edge = ecount;
        idle(4);
        check("full_latency", 32'(last_ready_edge - k_edge), 32'd2);
        n_ready_snap = n_ready;
        n_drop_snap  = n_drop;
        send(8'h0D);
        send(8'h0A);
        idle(14);
        check("crlf_no_ready", n_ready, n_ready_snap);
        check("crlf_no_drop", n_drop, n_drop_snap);

        // Byte arriving during padding is dropped
        n_drop_snap = n_drop;
        send("A");
        send(8'h0D);
        send("Z");
        idle(14);
        check("busy_drop_count", n_drop, n_drop_snap + 1);
        check("busy_slot0", String[0:6], 7'h41);
        check("busy_slot1", String[7:13], 7'h20);
        send_str("QR");
        send(8'h0D);
        idle(14);
        check("clean_slot1", String[7:13], 7'h52);
        check("clean_slot2", String[14:20], 7'h20);

        // Filtered bytes leave everything untouched
        n_drop_snap = n_drop;
        step(1'b1, 1'b1, 8'h42);
        send(8'hC1);
        send(8'h0A);
        idle(2);
        check("filter_char", CharSalida, 7'h52);
        check("filter_no_drop", n_drop, n_drop_snap);
        send("x");
        send(8'h0D);
        idle(14);
`ifdef POV_STRING_PACKER_UPCASE_EN
        exp_x = 7'h58;
`else
        exp_x = 7'h78;
`endif
        check("lower_slot0", String[0:6], exp_x);

        // Reset mid-message discards the partial text
        send_str("AB");
        pulse_reset();
        send("C");
        send(8'h0D);
        idle(14);
        check("midrst_slot0", String[0:6], 7'h43);
        check("midrst_slot1", String[7:13], 7'h20);

        // Randomized traffic
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (cyc == 1200) pulse_reset();
            if ($urandom_range(0, 1) == 0) begin
                idle(1);
            end else begin
                case ($urandom_range(0, 15))
                    0, 1, 2, 3, 4, 5, 6, 7: b = 8'h41 + 8'($urandom_range(0, 25));
                    8, 9, 10:               b = 8'h61 + 8'($urandom_range(0, 25));
                    11, 12:                 b = 8'h0D;
                    13:                     b = 8'h0A;
                    14:                     b = 8'h80 | 8'($urandom_range(0, 127));
                    default:                b = 8'($urandom_range(0, 255));
                endcase
                step(1'b1, ($urandom_range(0, 15) == 0), b);
            end
        end
        idle(16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
